uart_rx_buffer: RTL and testbench

UART_RX_BUFFER -- requirements
Module: uart_rx_buffer

---
 rtl/uart_rx_buffer.sv | 138 +++++++++++++
 tb/tb_uart_rx_buffer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_buffer.sv
// Show-ahead receive FIFO behind a UART receiver, with sticky overrun/frame-error flags.
// Optional macro UART_RX_BUFFER_ERRTAG_EN stores a 9th error-tag bit and queues a marker on rxErr.
module uart_rx_buffer #(
  parameter int Depth = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               rxData,
  input  logic                     rxDone,
  input  logic                     rxErr,
  output logic [7:0]               readData,
  output logic                     readErr,
  output logic                     readValid,
  input  logic                     readReady,
  output logic [$clog2(Depth):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overrun,
  output logic                     frameErr,
  input  logic                     clearErr
);

  localparam int AW = $clog2(Depth);
  localparam logic [AW:0] DEPTH_C = Depth[AW:0];
`ifdef UART_RX_BUFFER_ERRTAG_EN
  localparam int W = 9;
`else
  localparam int W = 8;
`endif

  logic [W-1:0] mem [Depth];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [AW:0]  wr_ptr_next;
  logic [AW:0]  rd_ptr_next;
  logic         overrun_next;
  logic         frame_err_next;
  logic         push_req;
  logic [W-1:0] push_entry;
  logic         push;
  logic         pop;
  logic         drop;
  logic [W-1:0] head;

  // Occupancy is the pointer difference; the extra MSB separates full from empty.
  always_comb begin
    count = wr_ptr - rd_ptr;
    full  = (count == DEPTH_C);
    empty = (count == {(AW+1){1'b0}});
  end

  // Translate receiver pulses into a push request; rxErr always overrides rxDone.
  always_comb begin
    push_req   = 1'b0;
    push_entry = {W{1'b0}};
`ifdef UART_RX_BUFFER_ERRTAG_EN
    if (rxErr) begin
      push_req   = 1'b1;
      push_entry = {1'b1, 8'h00};
    end else if (rxDone) begin
      push_req   = 1'b1;
      push_entry = {1'b0, rxData};
    end else begin
      push_req   = 1'b0;
    end
`else
    if (rxDone && !rxErr) begin
      push_req   = 1'b1;
      push_entry = rxData;
    end else begin
      push_req   = 1'b0;
    end
`endif
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    pop            = readValid && readReady;
    push           = push_req && (!full || pop);
    drop           = push_req && full && !pop;
    wr_ptr_next    = push ? wr_ptr + {{AW{1'b0}}, 1'b1} : wr_ptr;
    rd_ptr_next    = pop ? rd_ptr + {{AW{1'b0}}, 1'b1} : rd_ptr;
    if (drop) begin
      overrun_next = 1'b1;
    end else if (clearErr) begin
      overrun_next = 1'b0;
    end else begin
      overrun_next = overrun;
    end
    if (rxErr) begin
      frame_err_next = 1'b1;
    end else if (clearErr) begin
      frame_err_next = 1'b0;
    end else begin
      frame_err_next = frameErr;
    end
  end

  // Pointer and sticky-flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= {(AW+1){1'b0}};
      rd_ptr   <= {(AW+1){1'b0}};
      overrun  <= 1'b0;
      frameErr <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_next;
      rd_ptr   <= rd_ptr_next;
      overrun  <= overrun_next;
      frameErr <= frame_err_next;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wr_ptr[AW-1:0]] <= push_entry;
    end
  end

  // Head is forced to zero while empty so stale storage never shows.
  always_comb begin
    head      = mem[rd_ptr[AW-1:0]];
    readValid = !empty;
    if (empty) begin
      readData = 8'h00;
      readErr  = 1'b0;
    end else begin
      readData = head[7:0];
`ifdef UART_RX_BUFFER_ERRTAG_EN
      readErr  = head[8];
`else
      readErr  = 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed self-checking bench for uart_rx_buffer (Depth=8); expectations follow
// the UART_RX_BUFFER_ERRTAG_EN setting of the build.
module tb_uart_rx_buffer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rxData = 8'h00;
  logic       rxDone = 1'b0;
  logic       rxErr = 1'b0;
  logic [7:0] readData;
  logic       readErr;
  logic       readValid;
  logic       readReady = 1'b0;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       overrun;
  logic       frameErr;
  logic       clearErr = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;

  uart_rx_buffer #(.Depth(8)) dut (
    .clk(clk), .reset(reset), .rxData(rxData), .rxDone(rxDone), .rxErr(rxErr),
    .readData(readData), .readErr(readErr), .readValid(readValid), .readReady(readReady),
    .count(count), .full(full), .empty(empty), .overrun(overrun), .frameErr(frameErr),
    .clearErr(clearErr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    rxData = b; rxDone = 1'b1;
    tick();
    rxDone = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", full); end
    n_cmp++; if (readValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", readValid); end
    n_cmp++; if ({overrun, frameErr} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b want 00", {overrun, frameErr}); end
    n_cmp++; if ({readErr, readData} !== 9'h000) begin n_fail++; $display("FAIL reset_head got %h want 000", {readErr, readData}); end
  endtask

  task automatic test_basic();
    push_byte(8'h5A);
    n_cmp++; if (readValid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b want 1", readValid); end
    n_cmp++; if (readData !== 8'h5A) begin n_fail++; $display("FAIL basic_data got %h want 5a", readData); end
    n_cmp++; if (count !== 4'd1) begin n_fail++; $display("FAIL basic_count got %0d want 1", count); end
    readReady = 1'b1;
    tick();
    readReady = 1'b0;
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL basic_empty got %b want 1", empty); end
    // readReady while empty must not underflow
    readReady = 1'b1;
    tick();
    readReady = 1'b0;
    n_cmp++; if (count !== 4'd0) begin n_fail++; $display("FAIL underflow_count got %0d want 0", count); end
  endtask

  task automatic test_full_overrun();
    for (int i = 0; i < 8; i++) push_byte(i[7:0]);
    n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL ovr_full got %b want 1", full); end
    n_cmp++; if (count !== 4'd8) begin n_fail++; $display("FAIL ovr_count got %0d want 8", count); end
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_pre got %b want 0", overrun); end
    push_byte(8'hFF);
    n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set got %b want 1", overrun); end
    n_cmp++; if (count !== 4'd8) begin n_fail++; $display("FAIL ovr_count9 got %0d want 8", count); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (readData !== i[7:0]) begin n_fail++; $display("FAIL ovr_drain%0d got %h want %h", i, readData, i[7:0]); end
      readReady = 1'b1;
      tick();
      readReady = 1'b0;
    end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ovr_empty got %b want 1", empty); end
    clearErr = 1'b1;
    tick();
    clearErr = 1'b0;
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear got %b want 0", overrun); end
  endtask

  task automatic test_full_pop_push();
    logic [7:0] exp [8];
    for (int i = 0; i < 8; i++) push_byte(8'h10 + i[7:0]);
    rxData = 8'hAA; rxDone = 1'b1; readReady = 1'b1;
    tick();
    rxDone = 1'b0; readReady = 1'b0;
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL fpp_overrun got %b want 0", overrun); end
    n_cmp++; if (count !== 4'd8) begin n_fail++; $display("FAIL fpp_count got %0d want 8", count); end
    exp = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'hAA};
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (readData !== exp[i]) begin n_fail++; $display("FAIL fpp_drain%0d got %h want %h", i, readData, exp[i]); end
      readReady = 1'b1;
      tick();
      readReady = 1'b0;
    end
  endtask

  task automatic test_err();
    rxData = 8'h33; rxDone = 1'b1; rxErr = 1'b1;
    tick();
    rxDone = 1'b0; rxErr = 1'b0;
    n_cmp++; if (frameErr !== 1'b1) begin n_fail++; $display("FAIL err_frame got %b want 1", frameErr); end
`ifdef UART_RX_BUFFER_ERRTAG_EN
    n_cmp++; if ({readValid, readErr, readData} !== 10'h300) begin n_fail++; $display("FAIL err_head got %h want 300", {readValid, readErr, readData}); end
    readReady = 1'b1;
    tick();
    readReady = 1'b0;
`else
    n_cmp++; if ({empty, readErr, count} !== 6'b100000) begin n_fail++; $display("FAIL err_empty got %b want 100000", {empty, readErr, count}); end
`endif
    clearErr = 1'b1;
    tick();
    clearErr = 1'b0;
    n_cmp++; if (frameErr !== 1'b0) begin n_fail++; $display("FAIL err_clear got %b want 0", frameErr); end
  endtask

  task automatic test_clear_race();
    for (int i = 0; i < 8; i++) push_byte(i[7:0]);
    rxData = 8'hEE; rxDone = 1'b1; clearErr = 1'b1;
    tick();
    rxDone = 1'b0;
    n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL race_overrun got %b want 1", overrun); end
    rxErr = 1'b1;
    tick();
    rxErr = 1'b0;
    n_cmp++; if (frameErr !== 1'b1) begin n_fail++; $display("FAIL race_frame got %b want 1", frameErr); end
    tick();
    clearErr = 1'b0;
    n_cmp++; if ({overrun, frameErr} !== 2'b00) begin n_fail++; $display("FAIL race_clear got %b want 00", {overrun, frameErr}); end
    n_cmp++; if (count !== 4'd8) begin n_fail++; $display("FAIL race_count got %0d want 8", count); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q [$];
    logic [7:0] v;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) push_byte(8'hC0 + i[7:0]);
    reset = 1'b1; rxDone = 1'b1; rxErr = 1'b1; readReady = 1'b1;
    tick();
    reset = 1'b0; rxDone = 1'b0; rxErr = 1'b0; readReady = 1'b0;
    n_cmp++; if ({count, readValid} !== 5'b00000) begin n_fail++; $display("FAIL midreset got %b want 00000", {count, readValid}); end
    n_cmp++; if ({frameErr, readData} !== 9'h000) begin n_fail++; $display("FAIL midreset_state got %h want 000", {frameErr, readData}); end
    for (int k = 0; k < 20; k++) begin
      v = 8'(k * 37 + 5);
      readReady = (k >= 2);
      if (k >= 2) begin
        n_cmp++; if (readData !== q[0]) begin n_fail++; $display("FAIL b2b_data%0d got %h want %h", k, readData, q[0]); end
        void'(q.pop_front());
      end
      rxData = v; rxDone = 1'b1;
      tick();
      q.push_back(v);
      n_cmp++; if (count !== 4'(q.size())) begin n_fail++; $display("FAIL b2b_count%0d got %0d want %0d", k, count, q.size()); end
    end
    rxDone = 1'b0; readReady = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_overrun();
    test_full_pop_push();
    test_err();
    test_clear_race();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
